xosera_bus_sync: RTL and testbench

Bus front-end between the UPduino top-level bus pins and xosera_main. It synchronizes the asynchronous 8-bit m68k-style bus into the pclk domain and filters glitches on select. It emits exactly one single-cycle read or write strobe per valid chip-select assertion, with register number, byte select and write data captured alongside.

---
 rtl/xosera_bus_sync.sv | 142 ++++++++++++++
 tb/tb_xosera_bus_sync.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xosera_bus_sync.sv
// Bus front-end: synchronizes the asynchronous 8-bit host bus into the pixel clock domain
// and turns each valid chip-select assertion into one read or write strobe with captured fields.
module xosera_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_DELAY  = 1
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       bus_cs_n_i,
  input  logic       bus_rd_nwr_i,
  input  logic       bus_bytesel_i,
  input  logic [3:0] bus_reg_num_i,
  input  logic [7:0] bus_data_i,
  output logic       bus_write_strobe_o,
  output logic       bus_read_strobe_o,
  output logic [3:0] bus_reg_num_o,
  output logic       bus_bytesel_o,
  output logic [7:0] bus_data_o,
  output logic       bus_abort_o
);

  typedef enum logic [1:0] {IDLE, DELAY, WAIT_REL} state_t;

  localparam bit         NO_DELAY   = (DATA_DELAY == 0);
  localparam logic [2:0] DELAY_INIT = 3'((DATA_DELAY > 0) ? (DATA_DELAY - 1) : 0);

  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_rdSync;
  logic [SYNC_STAGES-1:0] r_byteSync;
  logic [3:0]             r_regSync  [SYNC_STAGES];
  logic [7:0]             r_dataSync [SYNC_STAGES];
  logic                   r_csP;
  logic [SYNC_STAGES-1:0] r_primed;
  logic                   r_seenHigh;

  state_t     r_state;
  logic [2:0] r_count;
  logic       r_writeStrobe;
  logic       r_readStrobe;
  logic       r_abort;
  logic [3:0] r_regNum;
  logic       r_bytesel;
  logic [7:0] r_data;

  logic w_csS;
  logic w_fall;
  logic w_capture;

  // A fall only counts once select has genuinely been seen high since reset, so a pin
  // already low when reset releases cannot be mistaken for a new access.
  assign w_csS     = r_csSync[SYNC_STAGES-1];
  assign w_fall    = r_seenHigh && r_csP && !w_csS;
  assign w_capture = ((r_state == IDLE) && w_fall && NO_DELAY) ||
                     ((r_state == DELAY) && !w_csS && (r_count == 3'd0));

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_csSync      <= '1;
      r_rdSync      <= '0;
      r_byteSync    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_regSync[i]  <= 4'd0;
        r_dataSync[i] <= 8'd0;
      end
      r_csP         <= 1'b1;
      r_primed      <= '0;
      r_seenHigh    <= 1'b0;
      r_state       <= IDLE;
      r_count       <= 3'd0;
      r_writeStrobe <= 1'b0;
      r_readStrobe  <= 1'b0;
      r_abort       <= 1'b0;
      r_regNum      <= 4'd0;
      r_bytesel     <= 1'b0;
      r_data        <= 8'd0;
    end else begin
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], bus_cs_n_i};
      r_rdSync   <= {r_rdSync[SYNC_STAGES-2:0], bus_rd_nwr_i};
      r_byteSync <= {r_byteSync[SYNC_STAGES-2:0], bus_bytesel_i};
      r_regSync[0]  <= bus_reg_num_i;
      r_dataSync[0] <= bus_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_regSync[i]  <= r_regSync[i-1];
        r_dataSync[i] <= r_dataSync[i-1];
      end
      r_csP    <= w_csS;
      r_primed <= {r_primed[SYNC_STAGES-2:0], 1'b1};
      if (r_primed[SYNC_STAGES-1] && w_csS) begin
        r_seenHigh <= 1'b1;
      end

      r_writeStrobe <= 1'b0;
      r_readStrobe  <= 1'b0;
      r_abort       <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            if (NO_DELAY) begin
              r_state <= WAIT_REL;
            end else begin
              r_count <= DELAY_INIT;
              r_state <= DELAY;
            end
          end
        end
        DELAY: begin
          if (w_csS) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end else if (r_count == 3'd0) begin
            r_state <= WAIT_REL;
          end else begin
            r_count <= r_count - 3'd1;
          end
        end
        WAIT_REL: begin
          if (w_csS) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_capture) begin
        r_regNum      <= r_regSync[SYNC_STAGES-1];
        r_bytesel     <= r_byteSync[SYNC_STAGES-1];
        r_data        <= r_dataSync[SYNC_STAGES-1];
        r_writeStrobe <= !r_rdSync[SYNC_STAGES-1];
        r_readStrobe  <= r_rdSync[SYNC_STAGES-1];
      end
    end
  end

  assign bus_write_strobe_o = r_writeStrobe;
  assign bus_read_strobe_o  = r_readStrobe;
  assign bus_reg_num_o      = r_regNum;
  assign bus_bytesel_o      = r_bytesel;
  assign bus_data_o         = r_data;
  assign bus_abort_o        = r_abort;

endmodule

// File: tb/tb_xosera_bus_sync.sv
// Directed bench for xosera_bus_sync: three instances with DATA_DELAY 1, 3 and 5,
// driven from a vector table plus hand-written reset sequences.
module tb_xosera_bus_sync;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] resetN;
  logic [2:0] csN;
  logic       rdNwr;
  logic       bytesel;
  logic [3:0] regNum;
  logic [7:0] dataIn;

  logic [2:0] wrStb;
  logic [2:0] rdStb;
  logic [2:0] byteOut;
  logic [2:0] abortOut;
  logic [3:0] regOut [3];
  logic [7:0] dataOut [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    xosera_bus_sync #(.SYNC_STAGES(SYNC), .DATA_DELAY(2 * g + 1)) dut (
      .clk               (clk),
      .reset_n_i         (resetN[g]),
      .bus_cs_n_i        (csN[g]),
      .bus_rd_nwr_i      (rdNwr),
      .bus_bytesel_i     (bytesel),
      .bus_reg_num_i     (regNum),
      .bus_data_i        (dataIn),
      .bus_write_strobe_o(wrStb[g]),
      .bus_read_strobe_o (rdStb[g]),
      .bus_reg_num_o     (regOut[g]),
      .bus_bytesel_o     (byteOut[g]),
      .bus_data_o        (dataOut[g]),
      .bus_abort_o       (abortOut[g])
    );
  end

  int cycleNum = 0;
  int wrCount [3] = '{0, 0, 0};
  int rdCount [3] = '{0, 0, 0};
  int abCount [3] = '{0, 0, 0};
  int bothCount [3] = '{0, 0, 0};
  int lastStbCycle [3] = '{0, 0, 0};

  // Tally strobes just after each rising edge so the stimulus side can read stable counts.
  always begin
    @(posedge clk);
    #1;
    cycleNum++;
    for (int i = 0; i < 3; i++) begin
      if (wrStb[i]) begin wrCount[i]++; lastStbCycle[i] = cycleNum; end
      if (rdStb[i]) begin rdCount[i]++; lastStbCycle[i] = cycleNum; end
      if (abortOut[i]) abCount[i]++;
      if (wrStb[i] && rdStb[i]) bothCount[i]++;
    end
  end

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  typedef struct {
    int         dut;
    logic       rdNwr;
    logic [3:0] regNum;
    logic       bytesel;
    logic [7:0] data;
    int         lowCycles;
    int         gapCycles;
    int         expWr;
    int         expRd;
    int         expAb;
    logic [3:0] expReg;
    logic       expByte;
    logic [7:0] expData;
  } vec_t;

  // One access: select low for lowCycles, high for gapCycles, then compare.
  task automatic applyStimulus(input vec_t v, input int idx);
    int wr0, rd0, ab0, fallCycle, dd;
    wr0 = wrCount[v.dut];
    rd0 = rdCount[v.dut];
    ab0 = abCount[v.dut];
    dd  = 2 * v.dut + 1;
    rdNwr   = v.rdNwr;
    regNum  = v.regNum;
    bytesel = v.bytesel;
    dataIn  = v.data;
    csN[v.dut] = 1'b0;
    fallCycle = cycleNum;
    repeat (v.lowCycles) @(negedge clk);
    csN[v.dut] = 1'b1;
    repeat (v.gapCycles) @(negedge clk);
    checkOutput($sformatf("vec%0d write strobes", idx), wrCount[v.dut] - wr0, v.expWr);
    checkOutput($sformatf("vec%0d read strobes", idx), rdCount[v.dut] - rd0, v.expRd);
    checkOutput($sformatf("vec%0d aborts", idx), abCount[v.dut] - ab0, v.expAb);
    checkOutput($sformatf("vec%0d reg_num", idx), regOut[v.dut], v.expReg);
    checkOutput($sformatf("vec%0d bytesel", idx), byteOut[v.dut], v.expByte);
    checkOutput($sformatf("vec%0d data", idx), dataOut[v.dut], v.expData);
    if (v.expWr + v.expRd > 0) begin
      checkOutput($sformatf("vec%0d latency", idx), lastStbCycle[v.dut] - fallCycle, SYNC + dd + 1);
    end
  endtask

  vec_t vecs [11];
  int expWrTot [3] = '{0, 0, 0};
  int expRdTot [3] = '{0, 0, 0};
  int expAbTot [3] = '{0, 0, 0};

  initial begin
    //          dut rd    reg    bs    data   low gap wr rd ab  eReg   eBs   eData
    vecs[0]  = '{0, 1'b0, 4'hA, 1'b1, 8'h5C, 8,  8,  1, 0, 0, 4'hA, 1'b1, 8'h5C};
    vecs[1]  = '{0, 1'b1, 4'h3, 1'b0, 8'h77, 10, 8,  0, 1, 0, 4'h3, 1'b0, 8'h77};
    vecs[2]  = '{0, 1'b1, 4'h6, 1'b1, 8'h00, 50, 8,  0, 1, 0, 4'h6, 1'b1, 8'h00};
    vecs[3]  = '{0, 1'b0, 4'h1, 1'b0, 8'h11, 6,  3,  1, 0, 0, 4'h1, 1'b0, 8'h11};
    vecs[4]  = '{0, 1'b0, 4'h2, 1'b0, 8'h22, 6,  8,  1, 0, 0, 4'h2, 1'b0, 8'h22};
    vecs[5]  = '{0, 1'b0, 4'hF, 1'b1, 8'hEE, 1,  8,  0, 0, 1, 4'h2, 1'b0, 8'h22};
    vecs[6]  = '{0, 1'b0, 4'h9, 1'b1, 8'h3C, 2,  8,  1, 0, 0, 4'h9, 1'b1, 8'h3C};
    vecs[7]  = '{1, 1'b0, 4'h7, 1'b1, 8'h99, 10, 8,  1, 0, 0, 4'h7, 1'b1, 8'h99};
    vecs[8]  = '{1, 1'b0, 4'hC, 1'b0, 8'h44, 3,  8,  0, 0, 1, 4'h7, 1'b1, 8'h99};
    vecs[9]  = '{1, 1'b1, 4'h4, 1'b1, 8'h81, 4,  8,  0, 1, 0, 4'h4, 1'b1, 8'h81};
    vecs[10] = '{2, 1'b0, 4'h5, 1'b0, 8'hA5, 8,  12, 1, 0, 0, 4'h5, 1'b0, 8'hA5};

    resetN  = 3'b000;
    csN     = 3'b000;
    rdNwr   = 1'b0;
    bytesel = 1'b0;
    regNum  = 4'h0;
    dataIn  = 8'h00;

    // Reset with select pins already low: nothing may fire after release.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d reset strobes", i), {wrStb[i], rdStb[i], abortOut[i]}, 3'b000);
      checkOutput($sformatf("dut%0d reset outputs", i), {regOut[i], byteOut[i], dataOut[i]}, 13'h0);
    end
    resetN = 3'b111;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d no access after low reset", i),
                  wrCount[i] + rdCount[i] + abCount[i], 0);
    end
    csN = 3'b111;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k], k);
      expWrTot[vecs[k].dut] += vecs[k].expWr;
      expRdTot[vecs[k].dut] += vecs[k].expRd;
      expAbTot[vecs[k].dut] += vecs[k].expAb;
    end

    // Reset while instance 2 (DATA_DELAY 5) sits in its delay window.
    regNum = 4'hB;
    dataIn = 8'h6D;
    csN[2] = 1'b0;
    repeat (3) @(negedge clk);
    resetN[2] = 1'b0;
    @(negedge clk);
    checkOutput("mid-delay reset strobes", {wrStb[2], rdStb[2], abortOut[2]}, 3'b000);
    checkOutput("mid-delay reset outputs", {regOut[2], byteOut[2], dataOut[2]}, 13'h0);
    repeat (2) @(negedge clk);
    resetN[2] = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post-reset dut2 write strobes", wrCount[2], expWrTot[2]);
    checkOutput("post-reset dut2 aborts", abCount[2], expAbTot[2]);
    csN[2] = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d total writes", i), wrCount[i], expWrTot[i]);
      checkOutput($sformatf("dut%0d total reads", i), rdCount[i], expRdTot[i]);
      checkOutput($sformatf("dut%0d total aborts", i), abCount[i], expAbTot[i]);
      checkOutput($sformatf("dut%0d both strobes", i), bothCount[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
